id_ex_reg: RTL
==============

// Module: id_ex_reg
// PURPOSE
//  ID/EX pipeline register between the decode stage and the execute stage.
//  Captures decoded operands, addresses and control for one cycle, then presents them to ex.
//  Supports stall (hold), flush on a taken jump/branch, and bubble insertion.
//  Also keeps saturating stall/flush event counters for debug and performance readout.
// PARAMETERS
//  NOP_INST     32'h0000_0013  instruction word loaded on bubble/flush (addi x0,x0,0)
//  RST_ADDR     32'h0000_0000  inst_addr_o value after reset/flush
//  CNT_W        16             width of the hold/flush event counters
// PORTS
//  clk            in   1      clock; all state updates on rising edge
//  rst            in   1      reset; synchronous, active-high
//  inst_i         in   32     instruction word from id
//  inst_addr_i    in   32     PC of inst_i
//  op1_i          in   32     ALU operand 1
//  op2_i          in   32     ALU operand 2
//  rd_addr_i      in   5      destination register index
//  reg_wen_i      in   1      destination write enable
//  base_addr_i    in   32     jump/branch base address
//  addr_offset_i  in   32     jump/branch sign-extended offset
//  id_valid_i     in   1      1 = id presents a real instruction this cycle
//  hold_i         in   1      stall from ctrl: keep current contents
//  flush_i        in   1      taken jump/branch from ex (jump_en): kill contents
//  inst_o .. addr_offset_o  out  as inputs  registered copies toward ex
//  valid_o        out  1      registered instruction is real (0 = bubble)
//  hold_cnt_o     out  CNT_W  cycles in which a hold was applied
//  flush_cnt_o    out  CNT_W  cycles in which a flush was applied
// BEHAVIOUR
//  - Latency: 1 cycle; inputs sampled at edge N appear on outputs after edge N.
//  - Per-edge priority: rst > flush_i > hold_i > load.
//  - Bubble value: inst_o=NOP_INST, inst_addr_o=RST_ADDR, op1/op2/base/offset=0, rd_addr_o=0,
//    reg_wen_o=0, valid_o=0.
//  - rst=1: all payload outputs take bubble value; both counters cleared to 0.
//    Reset mid-hold or mid-flush discards everything; no counter increment in that cycle.
//  - flush_i=1: load bubble value, regardless of hold_i or id_valid_i; flush_cnt_o += 1.
//    When hold_i is also 1, hold_cnt_o does NOT increment (flush consumed the cycle).
//  - hold_i=1, flush_i=0: all payload outputs and valid_o keep their values; hold_cnt_o += 1.
//  - load (neither): if id_valid_i=1, capture all inputs, valid_o=1;
//    if id_valid_i=0, load bubble value.
//  - Counters saturate at 2^CNT_W-1; they never wrap.
//  - reg_wen_o is forced to 0 whenever valid_o=0. x0 writes pass through unchanged
//    (the register file ignores them).
//  - No combinational path from any input to any output.
// TESTING
//  1. rst=1 for 2 cycles -> inst_o=32'h13, valid_o=0, reg_wen_o=0, both counters 0.
//  2. id_valid_i=1, inst_i=32'h00500093, op1_i=0, op2_i=5, rd_addr_i=1, reg_wen_i=1
//     -> next cycle outputs match exactly, valid_o=1.
//  3. Load A, then hold_i=1 for 3 cycles while inputs change to B -> outputs stay A;
//     hold_cnt_o=3. Release -> B appears 1 cycle later.
//  4. flush_i=1 and hold_i=1 in the same cycle -> bubble loaded; flush_cnt_o=1,
//     hold_cnt_o unchanged.
//  5. CNT_W=4, hold_i=1 for 20 cycles -> hold_cnt_o reaches 15 and stays at 15.
//  6. rst asserted during a hold with counters at 7 -> next cycle bubble, counters 0;
//     reg_wen_o=0 throughout.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: carries decoded operands and control from decode to execute.
// Supports stall (hold), flush and bubble insertion, and counts hold/flush cycles.
module id_ex_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter logic [31:0] RST_ADDR = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic [31:0]      op1_i,
  input  logic [31:0]      op2_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             reg_wen_i,
  input  logic [31:0]      base_addr_i,
  input  logic [31:0]      addr_offset_i,
  input  logic             id_valid_i,
  input  logic             hold_i,
  input  logic             flush_i,
  output logic [31:0]      inst_o,
  output logic [31:0]      inst_addr_o,
  output logic [31:0]      op1_o,
  output logic [31:0]      op2_o,
  output logic [4:0]       rd_addr_o,
  output logic             reg_wen_o,
  output logic [31:0]      base_addr_o,
  output logic [31:0]      addr_offset_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] hold_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [31:0]      inst_q, inst_d;
  logic [31:0]      inst_addr_q, inst_addr_d;
  logic [31:0]      op1_q, op1_d;
  logic [31:0]      op2_q, op2_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic             reg_wen_q, reg_wen_d;
  logic [31:0]      base_addr_q, base_addr_d;
  logic [31:0]      addr_offset_q, addr_offset_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Priority below reset: flush, then hold, then load (real instruction or bubble).
  always_comb begin
    inst_d        = inst_q;
    inst_addr_d   = inst_addr_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    rd_addr_d     = rd_addr_q;
    reg_wen_d     = reg_wen_q;
    base_addr_d   = base_addr_q;
    addr_offset_d = addr_offset_q;
    valid_d       = valid_q;
    hold_cnt_d    = hold_cnt_q;
    flush_cnt_d   = flush_cnt_q;

    if (flush_i) begin
      inst_d        = NOP_INST;
      inst_addr_d   = RST_ADDR;
      op1_d         = '0;
      op2_d         = '0;
      rd_addr_d     = '0;
      reg_wen_d     = 1'b0;
      base_addr_d   = '0;
      addr_offset_d = '0;
      valid_d       = 1'b0;
      if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else if (hold_i) begin
      if (hold_cnt_q != CNT_MAX) hold_cnt_d = hold_cnt_q + CNT_ONE;
    end else if (id_valid_i) begin
      inst_d        = inst_i;
      inst_addr_d   = inst_addr_i;
      op1_d         = op1_i;
      op2_d         = op2_i;
      rd_addr_d     = rd_addr_i;
      reg_wen_d     = reg_wen_i;
      base_addr_d   = base_addr_i;
      addr_offset_d = addr_offset_i;
      valid_d       = 1'b1;
    end else begin
      inst_d        = NOP_INST;
      inst_addr_d   = RST_ADDR;
      op1_d         = '0;
      op2_d         = '0;
      rd_addr_d     = '0;
      reg_wen_d     = 1'b0;
      base_addr_d   = '0;
      addr_offset_d = '0;
      valid_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q        <= NOP_INST;
      inst_addr_q   <= RST_ADDR;
      op1_q         <= '0;
      op2_q         <= '0;
      rd_addr_q     <= '0;
      reg_wen_q     <= 1'b0;
      base_addr_q   <= '0;
      addr_offset_q <= '0;
      valid_q       <= 1'b0;
      hold_cnt_q    <= '0;
      flush_cnt_q   <= '0;
    end else begin
      inst_q        <= inst_d;
      inst_addr_q   <= inst_addr_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      rd_addr_q     <= rd_addr_d;
      reg_wen_q     <= reg_wen_d;
      base_addr_q   <= base_addr_d;
      addr_offset_q <= addr_offset_d;
      valid_q       <= valid_d;
      hold_cnt_q    <= hold_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign inst_o        = inst_q;
  assign inst_addr_o   = inst_addr_q;
  assign op1_o         = op1_q;
  assign op2_o         = op2_q;
  assign rd_addr_o     = rd_addr_q;
  // A bubble must never write the register file, even if a stale enable were held.
  assign reg_wen_o     = reg_wen_q & valid_q;
  assign base_addr_o   = base_addr_q;
  assign addr_offset_o = addr_offset_q;
  assign valid_o       = valid_q;
  assign hold_cnt_o    = hold_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule
